// File: rtl/even_counter_pkg.sv
// Shared types and constants for the even up-down counter and its sequence checker.
package even_counter_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } chk_state_t;

  localparam int   EVEN_STEP = 2;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DN    = 1'b1;

endpackage

// File: rtl/even_step.sv
// Next-state predictor for the even counter: steps by EVEN_STEP in the given
// direction, wrapping modulo 2^WIDTH.
module even_step
  import even_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(EVEN_STEP);

  assign next = (dir == DIR_DN) ? (q - STEP) : (q + STEP);

endmodule

// File: rtl/even_updown_checker.sv
// Observes the even up-down counter, predicts each next state, acquires lock
// after LOCK_LEN clean transitions and counts mismatches seen while locked.
module even_updown_checker
  import even_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int ERR_W    = 8,
  parameter int LOCK_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             y_in,
  input  logic             valid_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int               MC_W        = $clog2(LOCK_LEN + 1);
  localparam logic [MC_W-1:0]  LOCK_TARGET = MC_W'(LOCK_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  chk_state_t       state;
  logic [WIDTH-1:0] prev_q;
  logic             prev_y;
  logic [MC_W-1:0]  match_cnt;

  logic [WIDTH-1:0] pred;
  logic [WIDTH-1:0] next_pred;
  logic [MC_W-1:0]  match_inc;
  logic             is_match;
  logic             is_even;

  // pred checks the current sample; next_pred is what the sample being
  // accepted now implies for the following one, and feeds the expected port.
  even_step #(.WIDTH(WIDTH)) u_pred (
    .q    (prev_q),
    .dir  (prev_y),
    .next (pred)
  );

  even_step #(.WIDTH(WIDTH)) u_next_pred (
    .q    (q_in),
    .dir  (y_in),
    .next (next_pred)
  );

  assign is_match  = (q_in == pred);
  assign is_even   = ~q_in[0];
  assign match_inc = match_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNLOCKED;
      prev_q    <= '0;
      prev_y    <= DIR_UP;
      match_cnt <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      expected  <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (valid_in) begin
        case (state)
          UNLOCKED: begin
            if (is_even) begin
              prev_q    <= q_in;
              prev_y    <= y_in;
              match_cnt <= '0;
              expected  <= next_pred;
              state     <= ACQUIRE;
            end
          end

          ACQUIRE: begin
            if (is_match) begin
              prev_q    <= q_in;
              prev_y    <= y_in;
              match_cnt <= match_inc;
              expected  <= next_pred;
              if (match_inc >= LOCK_TARGET) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (is_even) begin
              prev_q    <= q_in;
              prev_y    <= y_in;
              match_cnt <= '0;
              expected  <= next_pred;
            end else begin
              expected <= '0;
              state    <= UNLOCKED;
            end
          end

          LOCKED: begin
            if (is_match) begin
              prev_q   <= q_in;
              prev_y   <= y_in;
              expected <= next_pred;
            end else begin
              // Errors are only counted here; an even miss re-acquires at once.
              err_pulse <= 1'b1;
              locked    <= 1'b0;
              if (err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
              end
              if (is_even) begin
                prev_q    <= q_in;
                prev_y    <= y_in;
                match_cnt <= '0;
                expected  <= next_pred;
                state     <= ACQUIRE;
              end else begin
                expected <= '0;
                state    <= UNLOCKED;
              end
            end
          end

          default: begin
            locked   <= 1'b0;
            expected <= '0;
            state    <= UNLOCKED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_even_updown_checker.sv
// Scenario bench for even_updown_checker: a reference model feeds a scoreboard
// checked every cycle, and each scenario task adds its own targeted checks.
module tb_even_updown_checker;

  localparam int LOCK_LEN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] q_in = 4'd0;
  logic       y_in = 1'b0;
  logic       valid_in = 1'b0;

  logic       locked, err_pulse;
  logic [7:0] err_count;
  logic [3:0] expected;
  logic       locked_s, err_pulse_s;
  logic [1:0] err_count_s;
  logic [3:0] expected_s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic       locked;
    logic       pulse;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int   m_state = 0;
  int   m_prev = 0;
  logic m_dir = 1'b0;
  int   m_run = 0;
  int   m_err = 0;
  int   m_err_s = 0;

  even_updown_checker #(.WIDTH(4), .ERR_W(8), .LOCK_LEN(LOCK_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .y_in      (y_in),
    .valid_in  (valid_in),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected)
  );

  even_updown_checker #(.WIDTH(4), .ERR_W(2), .LOCK_LEN(LOCK_LEN)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .y_in      (y_in),
    .valid_in  (valid_in),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s),
    .expected  (expected_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: compares every output against the model one edge later
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse || err_count !== e.cnt ||
          expected !== e.exp || err_count_s !== e.cnt_s || locked_s !== e.locked ||
          err_pulse_s !== e.pulse || expected_s !== e.exp) begin
        errors++;
        $display("[TB] FAIL sb cyc=%0d: got locked=%b pulse=%b cnt=%0d exp=%0d sat_cnt=%0d, want locked=%b pulse=%b cnt=%0d exp=%0d sat_cnt=%0d",
                 cyc, locked, err_pulse, err_count, expected, err_count_s,
                 e.locked, e.pulse, e.cnt, e.exp, e.cnt_s);
      end
    end
  end

  function automatic int model_pred();
    return (m_prev + (m_dir ? 14 : 2)) % 16;
  endfunction

  // Drive one cycle, advance the model, push its prediction, and return just
  // after the capturing edge so callers can read the outputs directly.
  task automatic step(input int q, input logic y, input logic v, input logic r);
    exp_t e;
    logic pulse;
    int   p;
    reset    = r;
    q_in     = q[3:0];
    y_in     = y;
    valid_in = v;
    pulse    = 1'b0;
    p        = model_pred();
    if (r) begin
      m_state = 0; m_prev = 0; m_dir = 1'b0; m_run = 0; m_err = 0; m_err_s = 0;
    end else if (v) begin
      if (m_state == 0) begin
        if (q % 2 == 0) begin
          m_prev = q; m_dir = y; m_run = 0; m_state = 1;
        end
      end else if (q == p) begin
        m_prev = q; m_dir = y;
        if (m_state == 1) begin
          m_run++;
          if (m_run >= LOCK_LEN) m_state = 2;
        end
      end else begin
        if (m_state == 2) begin
          pulse = 1'b1;
          if (m_err < 255) m_err++;
          if (m_err_s < 3) m_err_s++;
        end
        if (q % 2 == 0) begin
          m_prev = q; m_dir = y; m_run = 0; m_state = 1;
        end else begin
          m_state = 0;
        end
      end
    end
    e.due    = cyc + 1;
    e.locked = (m_state == 2);
    e.pulse  = pulse;
    e.cnt    = m_err[7:0];
    e.cnt_s  = m_err_s[1:0];
    e.exp    = (m_state == 0) ? 4'd0 : 4'(model_pred());
    sb.push_back(e);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 8'd0 || expected !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset: got locked=%b pulse=%b cnt=%0d exp=%0d, want all 0",
               locked, err_pulse, err_count, expected);
    end
  endtask

  task automatic test_lock();
    step(0, 0, 1, 0);
    step(2, 0, 1, 0);
    step(4, 0, 1, 0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_after_4: got locked=%b, want 1", locked);
    end
    step(6, 0, 1, 0);
    checks++;
    if (expected !== 4'd8 || err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL expected_after_6: got exp=%0d cnt=%0d, want exp=8 cnt=0", expected, err_count);
    end
  endtask

  task automatic test_wrap();
    int seq_q [5] = '{10, 12, 14, 0, 14};
    logic seq_y [5] = '{0, 0, 0, 1, 1};
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(seq_q[i], seq_y[i], 1, 0);
      checks++;
      if (err_pulse !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wrap_no_err[%0d]: got pulse=%b, want 0", i, err_pulse);
      end
    end
    checks++;
    if (expected !== 4'd12 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_down: got exp=%0d locked=%b, want exp=12 locked=1", expected, locked);
    end
  endtask

  task automatic test_skip();
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(2, 0, 1, 0);
    step(4, 0, 1, 0);
    step(8, 0, 1, 0);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL skip: got pulse=%b cnt=%0d locked=%b, want pulse=1 cnt=1 locked=0",
               err_pulse, err_count, locked);
    end
    step(10, 0, 1, 0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL skip_pulse_width: got pulse=%b, want 0", err_pulse);
    end
    step(12, 0, 1, 0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL relock: got locked=%b, want 1", locked);
    end
  endtask

  task automatic test_odd_and_gaps();
    step(7, 1, 0, 0);
    step(3, 1, 0, 0);
    checks++;
    if (err_pulse !== 1'b0 || expected !== 4'd14 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gap_hold: got pulse=%b exp=%0d locked=%b, want pulse=0 exp=14 locked=1",
               err_pulse, expected, locked);
    end
    step(14, 0, 1, 0);
    checks++;
    if (locked !== 1'b1 || expected !== 4'd0 || err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL after_gap: got locked=%b exp=%0d cnt=%0d, want locked=1 exp=0 cnt=1",
               locked, expected, err_count);
    end
    step(5, 0, 1, 0);
    checks++;
    if (err_pulse !== 1'b1 || locked !== 1'b0 || expected !== 4'd0 || err_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL odd: got pulse=%b locked=%b exp=%0d cnt=%0d, want pulse=1 locked=0 exp=0 cnt=2",
               err_pulse, locked, expected, err_count);
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(2, 0, 1, 0);
    step(4, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(8, 0, 1, 0);
      step(10, 0, 1, 0);
      step(12, 0, 1, 0);
    end
    checks++;
    if (err_count_s !== 2'd3 || err_count !== 8'd5) begin
      errors++;
      $display("[TB] FAIL saturate: got sat_cnt=%0d cnt=%0d, want sat_cnt=3 cnt=5", err_count_s, err_count);
    end
    step(8, 0, 1, 1);
    checks++;
    if (err_pulse !== 1'b0 || locked !== 1'b0 || err_count !== 8'd0 || expected !== 4'd0 ||
        err_pulse_s !== 1'b0 || err_count_s !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_priority: got pulse=%b locked=%b cnt=%0d exp=%0d sat_cnt=%0d, want all 0",
               err_pulse, locked, err_count, expected, err_count_s);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_lock();
    test_wrap();
    test_skip();
    test_odd_and_gaps();
    test_saturation();
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/even_updown_checker.md
# even_updown_checker

Sequence checker for the 4-bit even up-down counter. It samples the counter's state bus and direction input every clock and predicts the next even state: +2 when direction is up, −2 when down, modulo 2^WIDTH. It flags any deviation, keeps a saturating error count and reports lock status. It sits on the observing side of the counter, in bring-up and self-test paths, and is the consumer of the counter's state sequence.

## Interface
- `WIDTH`, 4: width of the observed state bus.
- `ERR_W`, 8: width of the error counter.
- `LOCK_LEN`, 2: consecutive correct transitions required to declare lock (≥1).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset; **synchronous, active-high**.
- `q_in`  in  WIDTH  observed counter state.
- `y_in`  in  1  observed direction: 0 = up, 1 = down. Applies to the transition after this sample.
- `valid_in`  in  1  sample qualifier. When low, the cycle is ignored.
- `locked`  out  1  checker is tracking a verified sequence.
- `err_pulse`  out  1  one-cycle pulse per detected mismatch while locked.
- `err_count`  out  ERR_W  saturating count of `err_pulse` events.
- `expected`  out  WIDTH  predicted next value of `q_in`; 0 when not tracking.

## Operation
- Internal registers:
  - `prev_q`, `prev_y`: last accepted sample.
  - `match_cnt`: counts up to `LOCK_LEN`.
  - FSM state: UNLOCKED, ACQUIRE, LOCKED.
- Prediction: `expected = prev_q + 2` if `prev_y == 0`, else `prev_q - 2`, truncated to WIDTH bits.
  - Up wraps 14→0.
  - Down wraps 0→14.
- A sample is odd if `q_in[0] == 1`. An odd sample is never legal.
- UNLOCKED:
  - Valid even sample: load `prev_q`/`prev_y`, set `match_cnt = 0`, go to ACQUIRE.
  - Odd sample: stay in UNLOCKED.
- ACQUIRE, on a valid sample:
  - Match: increment `match_cnt`, reload `prev`. Go to LOCKED when `match_cnt` reaches `LOCK_LEN`.
  - Mismatch with even sample: reload `prev`, clear `match_cnt`, stay in ACQUIRE.
  - Mismatch with odd sample: go to UNLOCKED.
  - No error is counted in ACQUIRE.
- LOCKED, on a valid sample:
  - Match: reload `prev`.
  - Mismatch: assert `err_pulse`, increment `err_count` (saturating at 2^ERR_W−1, no wrap), then go to ACQUIRE (even sample, reloaded) or UNLOCKED (odd sample).
- A direction change is legal on any sample. The new `y_in` affects only the next prediction.
- `valid_in` low: all registers hold, `err_pulse` = 0, and prediction does not advance.
- Reset values:
  - FSM = UNLOCKED, `locked` = 0, `err_pulse` = 0, `err_count` = 0, `expected` = 0.
  - `prev_q` = 0, `prev_y` = 0, `match_cnt` = 0.
- `reset` has priority over every other input, including mid-lock and mid-error.

## Timing
- All outputs are registered.
- A sample accepted at edge n affects outputs visible after edge n.
- `err_pulse` is high for exactly the one cycle after the offending sample's edge. Back-to-back mismatches in LOCKED are impossible, because the first mismatch leaves LOCKED.
- `locked` rises the cycle after the `LOCK_LEN`-th consecutive match, and falls the cycle after the mismatch (the same cycle as `err_pulse`).
- `expected` updates one cycle after each accepted sample. It is 0 while UNLOCKED.
- Latency from reset deassertion to `locked`, with clean valid input: 1 + `LOCK_LEN` samples.

## Structure
- Shared package `even_counter_pkg`:
  - State enum (UNLOCKED, ACQUIRE, LOCKED).
  - `EVEN_STEP = 2`.
  - Direction constants `DIR_UP = 0`, `DIR_DN = 1`.
- One sub-module, `even_step`: combinational, WIDTH-parameterized. Inputs `q`, `dir`; output the next even value with wrap.
- The top holds the FSM, sample registers, match counter and saturating error counter.

## Test plan
- **Reset and lock:** reset 2 cycles, then up sequence 0,2,4,6 with `y=0`, valid every cycle.
  - `locked` = 1 after the sample 4 edge.
  - `expected` = 8 after sample 6.
  - `err_count` = 0.
- **Wrap up and down:** lock on 10,12,14, then 0 with `y=0`; then `y=1` from 0 to 14.
  - No `err_pulse`.
  - `expected` = 12 after sample 14.
- **Injected skip:** while locked at 4 (up), drive 8.
  - `err_pulse` for 1 cycle, `err_count` = 1, `locked` = 0.
  - Re-lock after 10,12.
- **Odd value and gaps:** while locked, drive 5.
  - `err_pulse`, state UNLOCKED, `expected` = 0.
  - Gaps with `valid_in` = 0 between locked samples cause no errors and no advance.
- **Saturation and reset priority:** with `ERR_W=2`, inject 5 errors.
  - `err_count` holds 3.
  - Assert `reset` coincident with a mismatch: no `err_pulse`, all outputs 0 next cycle.
